// File: rtl/assert_tracker_pkg.sv
// Shared types and helpers for the assertion result tracker.
// Optional feature macro: ASSERT_TRACKER_TIMEOUT_EN (per-channel active-run timeout).
package assert_tracker_pkg;

    // Widest counter the saturating helper can handle
    localparam int MAX_CNT_W     = 32;
    // Default width of the per-channel pass/fail counters
    localparam int DEFAULT_CNT_W = 16;

    // Per-channel monitor state
    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_ACTIVE = 2'd1,
        MON_DONE   = 2'd2
    } mon_state_e;

    // Increment val by one, holding at max_val instead of wrapping
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] val,
        input logic [MAX_CNT_W-1:0] max_val
    );
        logic [MAX_CNT_W-1:0] res;
        if (val >= max_val) begin
            res = max_val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/assert_chan_tracker.sv
// One checker channel: edge detection of the terminal levels, evaluation FSM,
// saturating pass/fail counters and, with ASSERT_TRACKER_TIMEOUT_EN, an
// active-run timeout that is reported as a fail.
module assert_chan_tracker
    import assert_tracker_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pass,
    input  logic             fail,
    input  logic             active,
    output logic             pass_evt,
    output logic             fail_evt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((64'd1 << CNT_W) - 64'd1);

    mon_state_e       state_r;
    mon_state_e       state_n;
    logic             pass_q_r;
    logic             fail_q_r;
    logic [CNT_W-1:0] pass_cnt_r;
    logic [CNT_W-1:0] fail_cnt_r;
    logic             rise_pass_s;
    logic             rise_fail_s;
    logic             evt_s;
    logic             timeout_s;
    logic             done_exit_s;

    assign rise_pass_s = pass & ~pass_q_r;
    assign rise_fail_s = fail & ~fail_q_r;
    assign evt_s       = rise_pass_s | rise_fail_s;

    // A pass that coincides with a high fail level is reported as a fail only;
    // clear drops any event of its own cycle.
    assign pass_evt = ~clear & rise_pass_s & ~fail;
    assign fail_evt = ~clear & (rise_fail_s | timeout_s);

    assign pass_cnt = pass_cnt_r;
    assign fail_cnt = fail_cnt_r;

`ifdef ASSERT_TRACKER_TIMEOUT_EN
    localparam int RUN_W = $clog2(TIMEOUT + 1);

    logic [RUN_W-1:0] run_r;
    logic             to_r;

    // The run count includes the IDLE cycle that started the evaluation
    assign timeout_s   = (state_r == MON_ACTIVE) && active && !evt_s &&
                         (run_r == RUN_W'(TIMEOUT - 1));
    // After a timeout the channel waits for active to drop before re-arming
    assign done_exit_s = ~to_r | ~active;

    // Count consecutive active cycles of an open evaluation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= '0;
        end else if (clear || evt_s || timeout_s) begin
            run_r <= '0;
        end else if (state_r == MON_DONE || !active) begin
            run_r <= '0;
        end else begin
            run_r <= run_r + RUN_W'(1);
        end
    end

    // Remember that the current DONE phase was entered through a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_r <= 1'b0;
        end else if (clear) begin
            to_r <= 1'b0;
        end else if (timeout_s) begin
            to_r <= 1'b1;
        end else if (evt_s || (state_r == MON_DONE && state_n == MON_IDLE)) begin
            to_r <= 1'b0;
        end else begin
            to_r <= to_r;
        end
    end
`else
    assign timeout_s   = 1'b0;
    assign done_exit_s = 1'b1;
`endif

    // Edge registers track the levels continuously, clear included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q_r <= 1'b0;
            fail_q_r <= 1'b0;
        end else begin
            pass_q_r <= pass;
            fail_q_r <= fail;
        end
    end

    // Evaluation FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            MON_IDLE: begin
                if (evt_s) begin
                    state_n = MON_DONE;
                end else if (active) begin
                    state_n = MON_ACTIVE;
                end else begin
                    state_n = MON_IDLE;
                end
            end
            MON_ACTIVE: begin
                if (evt_s || timeout_s) begin
                    state_n = MON_DONE;
                end else if (active) begin
                    state_n = MON_ACTIVE;
                end else begin
                    state_n = MON_IDLE;
                end
            end
            MON_DONE: begin
                if (evt_s) begin
                    state_n = MON_DONE;
                end else if (!pass && !fail && done_exit_s) begin
                    state_n = MON_IDLE;
                end else begin
                    state_n = MON_DONE;
                end
            end
            default: begin
                state_n = MON_IDLE;
            end
        endcase
    end

    // Evaluation FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MON_IDLE;
        end else if (clear) begin
            state_r <= MON_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Saturating pass/fail counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
        end else if (clear) begin
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
        end else begin
            if (pass_evt) begin
                pass_cnt_r <= CNT_W'(sat_inc(MAX_CNT_W'(pass_cnt_r), CNT_MAX));
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
            if (fail_evt) begin
                fail_cnt_r <= CNT_W'(sat_inc(MAX_CNT_W'(fail_cnt_r), CNT_MAX));
            end else begin
                fail_cnt_r <= fail_cnt_r;
            end
        end
    end

endmodule

// File: rtl/assert_result_tracker.sv
// Collects assertion results from NUM_CHK checker FSMs: per-channel statistics,
// first-failure record, sticky fail/protocol flags and a channel readout mux.
// Optional feature macro: ASSERT_TRACKER_TIMEOUT_EN (forwarded to every channel).
module assert_result_tracker
    import assert_tracker_pkg::*;
#(
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TS_W    = 32,
    parameter int TIMEOUT = 64,
    localparam int SEL_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CHK-1:0] chk_pass,
    input  logic [NUM_CHK-1:0] chk_fail,
    input  logic [NUM_CHK-1:0] chk_active,
    input  logic               clear,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_pass_cnt,
    output logic [CNT_W-1:0]   rd_fail_cnt,
    output logic               any_fail,
    output logic               first_fail_valid,
    output logic [SEL_W-1:0]   first_fail_idx,
    output logic [TS_W-1:0]    first_fail_time,
    output logic               proto_err
);

    logic [CNT_W-1:0]   pass_cnt_s [NUM_CHK];
    logic [CNT_W-1:0]   fail_cnt_s [NUM_CHK];
    logic [NUM_CHK-1:0] fail_evt_s;
    logic               any_fail_evt_s;
    logic [SEL_W-1:0]   low_idx_s;
    logic [TS_W-1:0]    ts_r;
    logic               any_fail_r;
    logic               ff_valid_r;
    logic [SEL_W-1:0]   ff_idx_r;
    logic [TS_W-1:0]    ff_time_r;
    logic               proto_err_r;

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_chan
        assert_chan_tracker #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .pass     (chk_pass[g]),
            .fail     (chk_fail[g]),
            .active   (chk_active[g]),
            .pass_evt (),
            .fail_evt (fail_evt_s[g]),
            .pass_cnt (pass_cnt_s[g]),
            .fail_cnt (fail_cnt_s[g])
        );
    end

    // Free-running cycle timestamp, untouched by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // Lowest-index fail event wins the first-failure record
    always_comb begin
        any_fail_evt_s = |fail_evt_s;
        low_idx_s      = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            low_idx_s = fail_evt_s[i] ? SEL_W'(i) : low_idx_s;
        end
    end

    // Sticky flags and first-failure capture; fail_evt_s is already masked by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_fail_r  <= 1'b0;
            ff_valid_r  <= 1'b0;
            ff_idx_r    <= '0;
            ff_time_r   <= '0;
            proto_err_r <= 1'b0;
        end else if (clear) begin
            any_fail_r  <= 1'b0;
            ff_valid_r  <= 1'b0;
            ff_idx_r    <= '0;
            ff_time_r   <= '0;
            proto_err_r <= 1'b0;
        end else begin
            any_fail_r  <= any_fail_r | any_fail_evt_s;
            proto_err_r <= proto_err_r | (|(chk_pass & chk_fail));
            if (any_fail_evt_s && !ff_valid_r) begin
                ff_valid_r <= 1'b1;
                ff_idx_r   <= low_idx_s;
                ff_time_r  <= ts_r;
            end else begin
                ff_valid_r <= ff_valid_r;
                ff_idx_r   <= ff_idx_r;
                ff_time_r  <= ff_time_r;
            end
        end
    end

    // Readout mux; unpopulated channel numbers read as zero
    always_comb begin
        rd_pass_cnt = '0;
        rd_fail_cnt = '0;
        if (32'(rd_sel) < NUM_CHK) begin
            rd_pass_cnt = pass_cnt_s[rd_sel];
            rd_fail_cnt = fail_cnt_s[rd_sel];
        end else begin
            rd_pass_cnt = '0;
            rd_fail_cnt = '0;
        end
    end

    assign any_fail         = any_fail_r;
    assign first_fail_valid = ff_valid_r;
    assign first_fail_idx   = ff_idx_r;
    assign first_fail_time  = ff_time_r;
    assign proto_err        = proto_err_r;

endmodule

// File: tb/tb_assert_result_tracker.sv
// Scoreboard bench for assert_result_tracker: directed scenarios then random
// stimulus, each cycle checked against a behavioural model of the tracker.
module tb_assert_result_tracker;

    localparam int NCH  = 5;
    localparam int CW   = 4;
    localparam int TSW  = 32;
    localparam int TO   = 8;
    localparam int SW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] chk_pass = '0;
    logic [NCH-1:0] chk_fail = '0;
    logic [NCH-1:0] chk_active = '0;
    logic           clear = 1'b0;
    logic [SW-1:0]  rd_sel = '0;
    logic [CW-1:0]  rd_pass_cnt;
    logic [CW-1:0]  rd_fail_cnt;
    logic           any_fail;
    logic           first_fail_valid;
    logic [SW-1:0]  first_fail_idx;
    logic [TSW-1:0] first_fail_time;
    logic           proto_err;

    always #5 clk = ~clk;

    assert_result_tracker #(.NUM_CHK(NCH), .CNT_W(CW), .TS_W(TSW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .chk_pass(chk_pass), .chk_fail(chk_fail),
        .chk_active(chk_active), .clear(clear), .rd_sel(rd_sel),
        .rd_pass_cnt(rd_pass_cnt), .rd_fail_cnt(rd_fail_cnt), .any_fail(any_fail),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .first_fail_time(first_fail_time), .proto_err(proto_err)
    );

    typedef struct packed {
        int                       tgt;
        logic [NCH-1:0][CW-1:0]   pc;
        logic [NCH-1:0][CW-1:0]   fc;
        logic                     af;
        logic                     ffv;
        logic [SW-1:0]            ffi;
        logic [TSW-1:0]           fft;
        logic                     pe;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state: statistics plus the minimum evaluation bookkeeping
    int          m_pc[NCH], m_fc[NCH], m_run[NCH];
    bit          m_pq[NCH], m_fq[NCH], m_wait[NCH], m_to[NCH];
    bit          m_af, m_ffv, m_pe;
    int          m_ffi;
    int unsigned m_fft, m_ts;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every expectation whose edge has passed
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            e = q.pop_front();
            chk("sb_rd_pass", rd_pass_cnt, (rd_sel < NCH) ? e.pc[rd_sel] : 0);
            chk("sb_rd_fail", rd_fail_cnt, (rd_sel < NCH) ? e.fc[rd_sel] : 0);
            chk("sb_any_fail", any_fail, e.af);
            chk("sb_ff_valid", first_fail_valid, e.ffv);
            chk("sb_ff_idx", first_fail_idx, e.ffi);
            chk("sb_ff_time", first_fail_time, e.fft);
            chk("sb_proto_err", proto_err, e.pe);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pc[i] = 0; m_fc[i] = 0; m_run[i] = 0;
            m_pq[i] = 0; m_fq[i] = 0; m_wait[i] = 0; m_to[i] = 0;
        end
        m_af = 0; m_ffv = 0; m_pe = 0; m_ffi = 0; m_fft = 0; m_ts = 0;
    endtask

    task automatic model_step(input logic [NCH-1:0] p, input logic [NCH-1:0] f,
                              input logic [NCH-1:0] a, input logic clr);
        exp_t        x;
        bit          any_f;
        int          lo;
        int unsigned ts_s;
        ts_s  = m_ts;
        any_f = 0;
        lo    = -1;
        for (int i = 0; i < NCH; i++) begin
            bit rp, rf, tof;
            rp  = p[i] && !m_pq[i];
            rf  = f[i] && !m_fq[i];
            tof = 0;
            if (clr) begin
                m_pc[i] = 0; m_fc[i] = 0; m_run[i] = 0; m_wait[i] = 0; m_to[i] = 0;
            end else begin
                if (rp || rf) begin
                    if (rp && !f[i]) m_pc[i] = (m_pc[i] < CMAX) ? m_pc[i] + 1 : CMAX;
                    m_wait[i] = 1; m_run[i] = 0; m_to[i] = 0;
                end else if (m_wait[i]) begin
                    if (!p[i] && !f[i] && (!m_to[i] || !a[i])) begin
                        m_wait[i] = 0; m_to[i] = 0;
                    end
                end else if (a[i]) begin
                    m_run[i]++;
`ifdef ASSERT_TRACKER_TIMEOUT_EN
                    if (m_run[i] == TO) begin
                        tof = 1; m_wait[i] = 1; m_to[i] = 1; m_run[i] = 0;
                    end
`endif
                end else begin
                    m_run[i] = 0;
                end
                if (rf || tof) begin
                    m_fc[i] = (m_fc[i] < CMAX) ? m_fc[i] + 1 : CMAX;
                    any_f = 1;
                    if (lo < 0) lo = i;
                end
                if (p[i] && f[i]) m_pe = 1;
            end
            m_pq[i] = p[i];
            m_fq[i] = f[i];
        end
        if (clr) begin
            m_af = 0; m_ffv = 0; m_ffi = 0; m_fft = 0; m_pe = 0;
        end else if (any_f) begin
            m_af = 1;
            if (!m_ffv) begin
                m_ffv = 1; m_ffi = lo; m_fft = ts_s;
            end
        end
        m_ts++;
        x.tgt = cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            x.pc[i] = CW'(m_pc[i]);
            x.fc[i] = CW'(m_fc[i]);
        end
        x.af = m_af; x.ffv = m_ffv; x.ffi = SW'(m_ffi); x.fft = m_fft; x.pe = m_pe;
        q.push_back(x);
    endtask

    // Drive one cycle of inputs, record the expectation, move past the edge
    task automatic step(input logic [NCH-1:0] p, input logic [NCH-1:0] f,
                        input logic [NCH-1:0] a, input logic clr);
        chk_pass = p; chk_fail = f; chk_active = a; clear = clr;
        model_step(p, f, a, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int ch, input int ep, input int ef, input string name);
        rd_sel = SW'(ch);
        #1;
        chk({name, "_pass"}, rd_pass_cnt, ep);
        chk({name, "_fail"}, rd_fail_cnt, ef);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_pass"}, rd_pass_cnt, 0);
        chk({name, "_rd_fail"}, rd_fail_cnt, 0);
        chk({name, "_any_fail"}, any_fail, 0);
        chk({name, "_ff_valid"}, first_fail_valid, 0);
        chk({name, "_ff_idx"}, first_fail_idx, 0);
        chk({name, "_ff_time"}, first_fail_time, 0);
        chk({name, "_proto"}, proto_err, 0);
    endtask

    localparam logic [NCH-1:0] Z = '0;

    initial begin
        int guard;
        logic [NCH-1:0] rp, rf, ra;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Ch0: active two cycles, then pass held five cycles
        repeat (2) step(Z, Z, 5'b00001, 1'b0);
        repeat (5) step(5'b00001, Z, 5'b00001, 1'b0);
        repeat (2) step(Z, Z, Z, 1'b0);
        peek(0, 1, 0, "ch0_held_pass");
        chk("ch0_any_fail", any_fail, 0);

        // Ch2 fail at ts 10, ch1 fail at ts 20
        guard = 0;
        while (m_ts < 10 && guard < 20) begin step(Z, Z, Z, 1'b0); guard++; end
        chk("ts_reach_10", m_ts, 10);
        step(Z, 5'b00100, Z, 1'b0);
        chk("ff_any_fail_c11", any_fail, 1);
        guard = 0;
        while (m_ts < 20 && guard < 20) begin step(Z, 5'b00100, Z, 1'b0); guard++; end
        step(Z, 5'b00110, Z, 1'b0);
        chk("ff_idx_2", first_fail_idx, 2);
        chk("ff_time_10", first_fail_time, 10);
        peek(1, 0, 1, "ch1_fail");
        peek(2, 0, 1, "ch2_fail");
        step(Z, Z, Z, 1'b0);

        // Simultaneous fails on ch1 and ch3
        step(Z, Z, Z, 1'b1);
        step(Z, 5'b01010, Z, 1'b0);
        step(Z, Z, Z, 1'b0);
        chk("simul_ff_idx", first_fail_idx, 1);
        peek(1, 0, 1, "simul_ch1");
        peek(3, 0, 1, "simul_ch3");

        // Pass and fail together on ch0
        step(Z, Z, Z, 1'b1);
        step(5'b00001, 5'b00001, Z, 1'b0);
        step(Z, Z, Z, 1'b0);
        peek(0, 0, 1, "proto_ch0");
        chk("proto_err_set", proto_err, 1);

        // Saturation, then clear with a held fail level
        step(Z, Z, Z, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(5'b10000, Z, Z, 1'b0);
            step(Z, Z, Z, 1'b0);
        end
        peek(4, CMAX, 0, "sat_ch4");
        step(Z, 5'b00001, Z, 1'b0);
        step(Z, 5'b00001, Z, 1'b1);
        repeat (3) step(Z, 5'b00001, Z, 1'b0);
        peek(0, 0, 0, "clr_held_ch0");
        peek(4, 0, 0, "clr_ch4");
        chk("clr_any_fail", any_fail, 0);
        chk("clr_ff_valid", first_fail_valid, 0);

        // Ch3 active for TIMEOUT cycles with no result
        step(Z, Z, Z, 1'b0);
        repeat (TO) step(Z, Z, 5'b01000, 1'b0);
        step(Z, Z, Z, 1'b0);
`ifdef ASSERT_TRACKER_TIMEOUT_EN
        peek(3, 0, 1, "timeout_ch3");
        chk("timeout_ff_idx", first_fail_idx, 3);
`else
        peek(3, 0, 0, "no_timeout_ch3");
        chk("no_timeout_any_fail", any_fail, 0);
`endif

        // Out-of-range readout
        step(Z, Z, Z, 1'b1);
        step(5'b00001, 5'b00010, Z, 1'b0);
        peek(6, 0, 0, "rd_sel_oob");

        // Reset during an evaluation with a pass level held across it
        step(Z, Z, Z, 1'b0);
        step(5'b00100, Z, 5'b00101, 1'b0);
        peek(2, 1, 0, "pre_rst_ch2");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(5'b00100, Z, 5'b00101, 1'b0);
        peek(2, 1, 0, "post_rst_recount");

        // Randomised traffic against the model
        rp = '0; rf = '0; ra = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 5) == 0) ra[i] = ~ra[i];
                if ($urandom_range(0, 7) == 0) rp[i] = ~rp[i];
                if ($urandom_range(0, 9) == 0) rf[i] = ~rf[i];
            end
            rd_sel = SW'($urandom_range(0, 7));
            step(rp, rf, ra, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        // Drain remaining expectations within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
